mem_burst_sequencer: RTL

Burst request sequencer sitting directly upstream of the memory controller. Accepts burst commands (op, start address, length) over a valid/ready handshake and breaks each into single-beat requests on the controller's `rd_wr_valid`/`rd_wr_mem`/`mem_addr`/`wr_data` inputs. Write beats draw data from a streaming input. Read data returned by the controller is captured at a fixed latency and forwarded as a response stream tagged with a last-beat flag.

---
 rtl/mem_seq_pkg.sv | 15 +
 rtl/mem_seq_rd_pipe.sv | 46 ++++
 rtl/mem_burst_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the memory burst sequencer.
package mem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } state_e;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    localparam int RD_LATENCY_MAX = 8;

endpackage

// File: rtl/mem_seq_rd_pipe.sv
// Read-tracking shift pipe carrying {valid, last} for RD_LATENCY cycles.
module mem_seq_rd_pipe #(
    parameter int LAT = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic vld_i,
    input  logic last_i,
    output logic vld_o,
    output logic last_o,
    output logic any_o
);

    generate
        if (LAT == 0) begin : g_pass
            logic unused_lat0;
            assign unused_lat0 = clk_i ^ rst_i;
            assign vld_o  = vld_i;
            assign last_o = last_i;
            assign any_o  = vld_i;
        end else begin : g_pipe
            logic [LAT-1:0] vld_q;
            logic [LAT-1:0] last_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    vld_q  <= '0;
                    last_q <= '0;
                end else begin
                    vld_q[0]  <= vld_i;
                    last_q[0] <= last_i;
                    for (int i = 1; i < LAT; i++) begin
                        vld_q[i]  <= vld_q[i-1];
                        last_q[i] <= last_q[i-1];
                    end
                end
            end

            assign vld_o  = vld_q[LAT-1];
            assign last_o = last_q[LAT-1];
            // The beat currently at the controller is also in flight.
            assign any_o  = vld_i | (|vld_q);
        end
    endgenerate

endmodule

// File: rtl/mem_burst_sequencer.sv
// Splits burst commands into single-beat controller requests.
// Optional MEM_SEQ_STATS_EN adds saturating beat/stall counters.
module mem_burst_sequencer
    import mem_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_wr_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic                  wdata_valid_i,
    output logic                  wdata_ready_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  rd_wr_valid_o,
    output logic                  rd_wr_mem_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_last_o,
    output logic                  busy_o
`ifdef MEM_SEQ_STATS_EN
    ,
    output logic [31:0]           stat_rd_beats_o,
    output logic [31:0]           stat_wr_beats_o,
    output logic [31:0]           stat_wr_stalls_o
`endif
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  beat, beat_wr, beat_last;
    logic [ADDR_WIDTH-1:0] beat_addr;

    logic                  rd_wr_valid_q, rd_wr_valid_d;
    logic                  rd_wr_mem_q, rd_wr_mem_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  rd_last_q, rd_last_d;

    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_last_q, rsp_last_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic                  pipe_vld, pipe_last, pipe_any;

    // Reads issue beat 0 on the accepting edge; writes wait for data.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        beat      = 1'b0;
        beat_wr   = 1'b0;
        beat_last = 1'b0;
        beat_addr = addr_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    if (cmd_wr_i == OP_WR) begin
                        state_d = WR_BURST;
                        addr_d  = cmd_addr_i;
                        cnt_d   = cmd_len_i;
                    end else begin
                        beat      = 1'b1;
                        beat_addr = cmd_addr_i;
                        beat_last = (cmd_len_i == '0);
                        addr_d    = cmd_addr_i + ADDR_WIDTH'(1);
                        cnt_d     = cmd_len_i - LEN_WIDTH'(1);
                        state_d   = beat_last ? IDLE : RD_BURST;
                    end
                end
            end
            RD_BURST: begin
                beat      = 1'b1;
                beat_last = (cnt_q == '0);
                addr_d    = addr_q + ADDR_WIDTH'(1);
                cnt_d     = cnt_q - LEN_WIDTH'(1);
                if (beat_last) state_d = IDLE;
            end
            WR_BURST: begin
                if (wdata_valid_i) begin
                    beat      = 1'b1;
                    beat_wr   = 1'b1;
                    beat_last = (cnt_q == '0);
                    addr_d    = addr_q + ADDR_WIDTH'(1);
                    cnt_d     = cnt_q - LEN_WIDTH'(1);
                    if (beat_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_wr_valid_d = beat;
        rd_wr_mem_d   = beat ? beat_wr : rd_wr_mem_q;
        mem_addr_d    = beat ? beat_addr : mem_addr_q;
        wr_data_d     = (beat && beat_wr) ? wdata_i : wr_data_q;
        rd_last_d     = beat & ~beat_wr & beat_last;
        rsp_valid_d   = pipe_vld;
        rsp_last_d    = pipe_vld & pipe_last;
        rsp_data_d    = pipe_vld ? rd_data_i : rsp_data_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            cnt_q         <= '0;
            rd_wr_valid_q <= 1'b0;
            rd_wr_mem_q   <= 1'b0;
            mem_addr_q    <= '0;
            wr_data_q     <= '0;
            rd_last_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_last_q    <= 1'b0;
            rsp_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            rd_wr_valid_q <= rd_wr_valid_d;
            rd_wr_mem_q   <= rd_wr_mem_d;
            mem_addr_q    <= mem_addr_d;
            wr_data_q     <= wr_data_d;
            rd_last_q     <= rd_last_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_last_q    <= rsp_last_d;
            rsp_data_q    <= rsp_data_d;
        end
    end

    mem_seq_rd_pipe #(
        .LAT (RD_LATENCY)
    ) u_rd_pipe (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .vld_i  (rd_wr_valid_q & ~rd_wr_mem_q),
        .last_i (rd_last_q),
        .vld_o  (pipe_vld),
        .last_o (pipe_last),
        .any_o  (pipe_any)
    );

    assign cmd_ready_o   = (state_q == IDLE);
    assign wdata_ready_o = (state_q == WR_BURST);
    assign rd_wr_valid_o = rd_wr_valid_q;
    assign rd_wr_mem_o   = rd_wr_mem_q;
    assign mem_addr_o    = mem_addr_q;
    assign wr_data_o     = wr_data_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_last_o    = rsp_last_q;
    assign rsp_data_o    = rsp_data_q;
    assign busy_o        = (state_q != IDLE) | pipe_any | rsp_valid_q;

`ifdef MEM_SEQ_STATS_EN
    logic [31:0] st_rd_q, st_wr_q, st_stall_q;
    logic        wr_stall;

    assign wr_stall = (state_q == WR_BURST) & ~wdata_valid_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_rd_q    <= '0;
            st_wr_q    <= '0;
            st_stall_q <= '0;
        end else begin
            if (beat && !beat_wr && st_rd_q != '1)
                st_rd_q <= st_rd_q + 32'd1;
            if (beat && beat_wr && st_wr_q != '1)
                st_wr_q <= st_wr_q + 32'd1;
            if (wr_stall && st_stall_q != '1)
                st_stall_q <= st_stall_q + 32'd1;
        end
    end

    assign stat_rd_beats_o  = st_rd_q;
    assign stat_wr_beats_o  = st_wr_q;
    assign stat_wr_stalls_o = st_stall_q;
`endif

endmodule
